// File: rtl/stack_core_if.sv
// Program-memory fetch port and observable outputs of the stack core.
// master = core side, slave = memory / board side.
interface stack_core_if #(
  parameter int WIDTH = 16
);
  logic [14:0]      mem_addr;
  logic             mem_req;
  logic [15:0]      mem_rdata;
  logic             mem_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             halted;
  logic [2:0]       fault;

  modport master (
    output mem_addr, mem_req, out_data, out_valid, halted, fault,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_req, out_data, out_valid, halted, fault,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/stack_core.sv
// Stack-machine core: word fetch over mem_req/mem_ready, execution on parametrised data/return stacks.
// Word op 2 cycles, byte pair 3, odd-ip byte 2, plus one per fetch wait state; fault or HALT stops it until rst.
module stack_core #(
  parameter int WIDTH  = 16,
  parameter int DDEPTH = 16,
  parameter int RDEPTH = 16
)(
  input  logic         clk,
  input  logic         rst,
  stack_core_if.master bus
);
  localparam int DA = $clog2(DDEPTH);
  localparam int RA = $clog2(RDEPTH);
  localparam logic [DA:0] D_FULL = (DA+1)'(DDEPTH);
  localparam logic [RA:0] R_FULL = (RA+1)'(RDEPTH);

  typedef enum logic [2:0] {S_FETCH, S_EXEC_W, S_EXEC_H, S_EXEC_L, S_HALT} state_t;

  state_t           r_state;
  logic             r_mem_req;
  logic [15:0]      r_ip;
  logic [15:0]      r_instr;
  logic [DA:0]      r_dsp;
  logic [RA:0]      r_rsp;
  logic [WIDTH-1:0] r_dstk [DDEPTH];
  logic [WIDTH-1:0] r_rstk [RDEPTH];
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_halted;
  logic [2:0]       r_fault;

  logic [DA-1:0]    w_di0, w_di1, w_di2, w_di3;
  logic [RA-1:0]    w_ri0, w_ri1;
  logic [WIDTH-1:0] w_tos, w_nos, w_ros, w_rtos;
  logic [7:0]       w_op;
  logic [15:0]      w_ip_inc2, w_jmp, w_ip_nxt;
  logic             w_exec, w_commit;
  logic [1:0]       w_dneed;
  logic             w_dinc, w_ddec, w_rneed, w_rinc, w_rdec;
  logic             w_illegal, w_halt_op, w_out_en;
  logic             w_wr0, w_wr1, w_wr2, w_wr3, w_rwr;
  logic [WIDTH-1:0] w_wr0_dat, w_wr1_dat, w_wr2_dat, w_wr3_dat, w_rwr_dat;
  logic [2:0]       w_fcode;

  assign w_di0  = r_dsp[DA-1:0];
  assign w_di1  = w_di0 - DA'(1);
  assign w_di2  = w_di0 - DA'(2);
  assign w_di3  = w_di0 - DA'(3);
  assign w_ri0  = r_rsp[RA-1:0];
  assign w_ri1  = w_ri0 - RA'(1);
  assign w_tos  = r_dstk[w_di1];
  assign w_nos  = r_dstk[w_di2];
  assign w_ros  = r_dstk[w_di3];
  assign w_rtos = r_rstk[w_ri1];

  assign w_op      = (r_state == S_EXEC_H) ? r_instr[15:8] : r_instr[7:0];
  assign w_ip_inc2 = r_ip + 16'd2;
  assign w_jmp     = w_ip_inc2 + {{3{r_instr[12]}}, r_instr[12:0]};
  assign w_exec    = (r_state == S_EXEC_W) || (r_state == S_EXEC_H) || (r_state == S_EXEC_L);
  assign w_commit  = w_exec && (w_fcode == 3'd0) && !w_halt_op;

  // Stack writes are expressed relative to the pre-op dsp: wr0 at dsp, wr1..wr3 at dsp-1..dsp-3.
  always_comb begin
    w_dneed = 2'd0;  w_dinc = 1'b0;  w_ddec = 1'b0;
    w_rneed = 1'b0;  w_rinc = 1'b0;  w_rdec = 1'b0;
    w_illegal = 1'b0;  w_halt_op = 1'b0;  w_out_en = 1'b0;
    w_wr0 = 1'b0;  w_wr1 = 1'b0;  w_wr2 = 1'b0;  w_wr3 = 1'b0;  w_rwr = 1'b0;
    w_wr0_dat = '0;  w_wr1_dat = '0;  w_wr2_dat = '0;  w_wr3_dat = '0;  w_rwr_dat = '0;
    w_ip_nxt = r_ip + 16'd1;
    if (r_state == S_EXEC_W) begin
      w_ip_nxt = w_ip_inc2;
      if (r_instr[15]) begin
        w_dinc = 1'b1;  w_wr0 = 1'b1;  w_wr0_dat = WIDTH'(r_instr[14:0]);
      end else begin
        case (r_instr[14:13])
          2'b01: w_ip_nxt = w_jmp;
          2'b10: begin
            w_rinc = 1'b1;  w_rwr = 1'b1;  w_rwr_dat = WIDTH'(w_ip_inc2);  w_ip_nxt = w_jmp;
          end
          2'b11: begin
            w_dneed = 2'd1;  w_ddec = 1'b1;
            if (w_tos == '0) w_ip_nxt = w_jmp;
          end
          default: ;
        endcase
      end
    end else begin
      case (w_op)
        8'h00: ;
        8'h01: begin w_dneed = 2'd1; w_ddec = 1'b1; w_out_en = 1'b1; end
        8'h02, 8'h03, 8'h08, 8'h09, 8'h0A, 8'h0F, 8'h10, 8'h11: begin
          w_dneed = 2'd2;  w_ddec = 1'b1;  w_wr2 = 1'b1;
          case (w_op)
            8'h02:   w_wr2_dat = w_nos + w_tos;
            8'h03:   w_wr2_dat = w_nos - w_tos;
            8'h08:   w_wr2_dat = (w_nos < w_tos)  ? '1 : '0;
            8'h09:   w_wr2_dat = (w_nos > w_tos)  ? '1 : '0;
            8'h0A:   w_wr2_dat = (w_nos == w_tos) ? '1 : '0;
            8'h0F:   w_wr2_dat = w_nos & w_tos;
            8'h10:   w_wr2_dat = w_nos | w_tos;
            default: w_wr2_dat = w_nos ^ w_tos;
          endcase
        end
        8'h04: begin w_dneed = 2'd1; w_dinc = 1'b1; w_wr0 = 1'b1; w_wr0_dat = w_tos; end
        8'h05: begin
          w_dneed = 2'd2;
          w_wr1 = 1'b1;  w_wr1_dat = w_nos;  w_wr2 = 1'b1;  w_wr2_dat = w_tos;
        end
        8'h06: begin
          w_dneed = 2'd3;
          w_wr1 = 1'b1;  w_wr1_dat = w_ros;
          w_wr2 = 1'b1;  w_wr2_dat = w_tos;
          w_wr3 = 1'b1;  w_wr3_dat = w_nos;
        end
        8'h07: begin w_rneed = 1'b1; w_rdec = 1'b1; w_ip_nxt = w_rtos[15:0]; end
        8'h0B: begin w_dneed = 2'd1; w_wr1 = 1'b1; w_wr1_dat = ~w_tos; end
        8'h0C: begin
          w_dneed = 2'd1;  w_ddec = 1'b1;  w_rinc = 1'b1;  w_rwr = 1'b1;  w_rwr_dat = w_tos;
        end
        8'h0D: begin
          w_rneed = 1'b1;  w_rdec = 1'b1;  w_dinc = 1'b1;  w_wr0 = 1'b1;  w_wr0_dat = w_rtos;
        end
        8'h0E: begin w_rneed = 1'b1; w_dinc = 1'b1; w_wr0 = 1'b1; w_wr0_dat = w_rtos; end
        8'h12: begin w_dneed = 2'd1; w_ddec = 1'b1; end
        8'h13: begin w_halt_op = 1'b1; w_ip_nxt = r_ip; end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_fcode = 3'd0;
    if (w_illegal)                          w_fcode = 3'd5;
    else if (r_dsp < (DA+1)'(w_dneed))      w_fcode = 3'd2;
    else if (w_dinc && (r_dsp == D_FULL))   w_fcode = 3'd1;
    else if (r_rsp < (RA+1)'(w_rneed))      w_fcode = 3'd4;
    else if (w_rinc && (r_rsp == R_FULL))   w_fcode = 3'd3;
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (w_wr0) r_dstk[w_di0] <= w_wr0_dat;
      if (w_wr1) r_dstk[w_di1] <= w_wr1_dat;
      if (w_wr2) r_dstk[w_di2] <= w_wr2_dat;
      if (w_wr3) r_dstk[w_di3] <= w_wr3_dat;
      if (w_rwr) r_rstk[w_ri0] <= w_rwr_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_mem_req   <= 1'b1;
      r_ip        <= '0;
      r_instr     <= '0;
      r_dsp       <= '0;
      r_rsp       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_fault     <= 3'd0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            r_instr   <= bus.mem_rdata;
            r_mem_req <= 1'b0;
            if (r_ip[0])                             r_state <= S_EXEC_L;
            else if (bus.mem_rdata[15:13] != 3'd0)   r_state <= S_EXEC_W;
            else                                     r_state <= S_EXEC_H;
          end
        end
        S_EXEC_W, S_EXEC_H, S_EXEC_L: begin
          // A faulting op commits nothing; the low byte of a pair is dropped too.
          if ((w_fcode != 3'd0) || w_halt_op) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            r_fault  <= w_fcode;
          end else begin
            r_ip <= w_ip_nxt;
            if (w_dinc)      r_dsp <= r_dsp + (DA+1)'(1);
            else if (w_ddec) r_dsp <= r_dsp - (DA+1)'(1);
            if (w_rinc)      r_rsp <= r_rsp + (RA+1)'(1);
            else if (w_rdec) r_rsp <= r_rsp - (RA+1)'(1);
            if (w_out_en) begin
              r_out_data  <= w_tos;
              r_out_valid <= 1'b1;
            end
            if (r_state == S_EXEC_H) begin
              r_state <= S_EXEC_L;
            end else begin
              r_state   <= S_FETCH;
              r_mem_req <= 1'b1;
            end
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign bus.mem_addr  = r_ip[15:1];
  assign bus.mem_req   = r_mem_req;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.halted    = r_halted;
  assign bus.fault     = r_fault;
endmodule

// File: tb/tb_stack_core.sv
// Directed bench for stack_core: default-size core plus a DDEPTH=4 core for overflow.
module tb_stack_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] prog0 [32];
  logic [15:0] prog1 [32];
  int          waits = 0;
  logic        hold  = 1'b0;
  int          wcnt;
  logic [15:0] outq [$];

  always #5 clk = ~clk;

  stack_core_if #(.WIDTH(16)) if0 ();
  stack_core_if #(.WIDTH(16)) if1 ();

  stack_core #(.WIDTH(16), .DDEPTH(16), .RDEPTH(16)) dut  (.clk(clk), .rst(rst), .bus(if0));
  stack_core #(.WIDTH(16), .DDEPTH(4),  .RDEPTH(16)) dut4 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.mem_rdata = prog0[if0.mem_addr[4:0]];
  assign if0.mem_ready = !hold && (wcnt >= waits);
  assign if1.mem_rdata = prog1[if1.mem_addr[4:0]];
  assign if1.mem_ready = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst)                              wcnt <= 0;
    else if (if0.mem_req && if0.mem_ready) wcnt <= 0;
    else if (if0.mem_req)                  wcnt <= wcnt + 1;
  end

  always @(negedge clk) if (if0.out_valid) outq.push_back(if0.out_data);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    outq.delete();
    rst = 1'b0;
  endtask

  task automatic load_add();
    prog0 = '{default: 16'h0013};
    prog0[0] = 16'h8005;  prog0[1] = 16'h8003;  prog0[2] = 16'h0201;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (if0.mem_req !== 1'b1)    begin errors++; $display("FAIL reset_mem_req got %b want 1", if0.mem_req); end
    checks++; if (if0.mem_addr !== 15'd0)  begin errors++; $display("FAIL reset_mem_addr got %h want 0", if0.mem_addr); end
    checks++; if (if0.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", if0.out_valid); end
    checks++; if (if0.out_data !== 16'd0)  begin errors++; $display("FAIL reset_out_data got %h want 0", if0.out_data); end
    checks++; if (if0.halted !== 1'b0)     begin errors++; $display("FAIL reset_halted got %b want 0", if0.halted); end
    checks++; if (if0.fault !== 3'd0)      begin errors++; $display("FAIL reset_fault got %0d want 0", if0.fault); end
  endtask

  task automatic test_add_out();
    int vcyc = 0;
    int npulse = 0;
    load_add();
    waits = 0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (if0.out_valid) begin npulse++; if (vcyc == 0) vcyc = c; end
    end
    checks++; if (vcyc != 7)   begin errors++; $display("FAIL add_out_cycle got %0d want 7", vcyc); end
    checks++; if (npulse != 1) begin errors++; $display("FAIL add_out_pulses got %0d want 1", npulse); end
    checks++; if (outq.size() != 1 || outq[0] !== 16'd8)
      begin errors++; $display("FAIL add_out_data got n=%0d first=%h want n=1 8", outq.size(), (outq.size() > 0) ? outq[0] : 16'hxxxx); end
    checks++; if (dut.r_dsp !== 5'd0)   begin errors++; $display("FAIL add_out_dsp got %0d want 0", dut.r_dsp); end
    checks++; if (if0.halted !== 1'b1 || if0.fault !== 3'd0)
      begin errors++; $display("FAIL add_out_halt got halted=%b fault=%0d want 1 0", if0.halted, if0.fault); end
  endtask

  task automatic test_wait_states();
    int vcyc = 0;
    logic prev_stall = 1'b0;
    logic [14:0] prev_addr = '0;
    load_add();
    waits = 2;
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (prev_stall && if0.mem_req) begin
        checks++;
        if (if0.mem_addr !== prev_addr) begin errors++; $display("FAIL stall_addr got %h want %h", if0.mem_addr, prev_addr); end
      end
      prev_stall = if0.mem_req && !if0.mem_ready;
      prev_addr  = if0.mem_addr;
      if (if0.out_valid && vcyc == 0) vcyc = c;
    end
    checks++; if (vcyc != 13) begin errors++; $display("FAIL wait_out_cycle got %0d want 13", vcyc); end
    checks++; if (outq.size() != 1 || outq[0] !== 16'd8)
      begin errors++; $display("FAIL wait_out_data got n=%0d want n=1 value 8", outq.size()); end
    waits = 0;
  endtask

  task automatic test_call_ret();
    int hcyc = 0;
    prog0 = '{default: 16'h0013};
    prog0[0] = 16'h4002;  prog0[1] = 16'h0113;  prog0[2] = 16'h8007;  prog0[3] = 16'h0701;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (if0.halted && hcyc == 0) hcyc = c;
    end
    checks++; if (hcyc != 9) begin errors++; $display("FAIL call_halt_cycle got %0d want 9", hcyc); end
    checks++; if (outq.size() != 1 || outq[0] !== 16'd7)
      begin errors++; $display("FAIL call_out_data got n=%0d want n=1 value 7", outq.size()); end
    checks++; if (if0.fault !== 3'd0)    begin errors++; $display("FAIL call_fault got %0d want 0", if0.fault); end
    checks++; if (dut.r_rsp !== 5'd0)    begin errors++; $display("FAIL call_rsp got %0d want 0", dut.r_rsp); end
    checks++; if (if0.mem_addr !== 15'd1) begin errors++; $display("FAIL call_final_addr got %h want 1", if0.mem_addr); end
  endtask

  task automatic test_alu_branch();
    logic [15:0] exp [6] = '{16'hFFF9, 16'h0002, 16'h0000, 16'hFFFC, 16'hFFFF, 16'h000B};
    prog0 = '{default: 16'h0013};
    prog0[0]  = 16'h8003; prog0[1]  = 16'h800A; prog0[2]  = 16'h0301; prog0[3]  = 16'h8002;
    prog0[4]  = 16'h8009; prog0[5]  = 16'h8005; prog0[6]  = 16'h0601; prog0[7]  = 16'h0801;
    prog0[8]  = 16'h8003; prog0[9]  = 16'h0B01; prog0[10] = 16'h8004; prog0[11] = 16'h0405;
    prog0[12] = 16'h0A01; prog0[13] = 16'h8000; prog0[14] = 16'h6002; prog0[15] = 16'h0113;
    prog0[16] = 16'h8001; prog0[17] = 16'h6002; prog0[18] = 16'h2002; prog0[19] = 16'h0013;
    prog0[20] = 16'h800B; prog0[21] = 16'h0113;
    do_reset();
    for (int c = 1; c <= 120 && !if0.halted; c++) begin @(posedge clk); #1; end
    checks++; if (outq.size() != 6) begin errors++; $display("FAIL alu_out_count got %0d want 6", outq.size()); end
    for (int i = 0; i < 6 && i < outq.size(); i++) begin
      checks++;
      if (outq[i] !== exp[i]) begin errors++; $display("FAIL alu_out_%0d got %h want %h", i, outq[i], exp[i]); end
    end
    checks++; if (if0.halted !== 1'b1 || if0.fault !== 3'd0)
      begin errors++; $display("FAIL alu_end got halted=%b fault=%0d want 1 0", if0.halted, if0.fault); end
    checks++; if (dut.r_dsp !== 5'd0) begin errors++; $display("FAIL alu_dsp got %0d want 0", dut.r_dsp); end
  endtask

  task automatic test_overflow();
    int hcyc = 0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (if1.halted && hcyc == 0) hcyc = c;
    end
    checks++; if (hcyc != 10)          begin errors++; $display("FAIL ovf_cycle got %0d want 10", hcyc); end
    checks++; if (if1.fault !== 3'd1)  begin errors++; $display("FAIL ovf_fault got %0d want 1", if1.fault); end
    checks++; if (dut4.r_dsp !== 3'd4) begin errors++; $display("FAIL ovf_dsp got %0d want 4", dut4.r_dsp); end
    checks++; if (dut4.r_ip !== 16'd8) begin errors++; $display("FAIL ovf_ip got %0d want 8", dut4.r_ip); end
    checks++; if (if1.mem_addr !== 15'd4) begin errors++; $display("FAIL ovf_addr got %h want 4", if1.mem_addr); end
  endtask

  task automatic test_underflow();
    int hcyc = 0;
    prog0 = '{default: 16'h0013};
    prog0[0] = 16'h0213;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (if0.halted && hcyc == 0) hcyc = c;
    end
    checks++; if (hcyc != 2)           begin errors++; $display("FAIL unf_cycle got %0d want 2", hcyc); end
    checks++; if (if0.fault !== 3'd2)  begin errors++; $display("FAIL unf_fault got %0d want 2", if0.fault); end
    checks++; if (dut.r_ip !== 16'd0)  begin errors++; $display("FAIL unf_ip got %0d want 0", dut.r_ip); end
    checks++; if (outq.size() != 0)    begin errors++; $display("FAIL unf_out got %0d pulses want 0", outq.size()); end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    load_add();
    do_reset();
    for (int c = 1; c <= 30 && !found; c++) begin
      @(negedge clk);
      if (if0.mem_req && if0.mem_addr == 15'd3) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach_ip6 got timeout want fetch at addr 3"); end
    hold = 1'b1;
    checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending_valid got %b want 1", if0.out_valid); end
    @(negedge clk);
    checks++; if (if0.mem_addr !== 15'd3) begin errors++; $display("FAIL mid_stall_addr got %h want 3", if0.mem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (if0.mem_addr !== 15'd0 || if0.mem_req !== 1'b1)
      begin errors++; $display("FAIL mid_rst_fetch got addr=%h req=%b want 0 1", if0.mem_addr, if0.mem_req); end
    checks++; if (if0.out_data !== 16'd0 || if0.out_valid !== 1'b0)
      begin errors++; $display("FAIL mid_rst_out got data=%h vld=%b want 0 0", if0.out_data, if0.out_valid); end
    checks++; if (if0.halted !== 1'b0 || if0.fault !== 3'd0)
      begin errors++; $display("FAIL mid_rst_status got halted=%b fault=%0d want 0 0", if0.halted, if0.fault); end
    @(negedge clk);
    rst  = 1'b0;
    hold = 1'b0;
    @(posedge clk); #1;
    checks++; if (if0.mem_req !== 1'b0 || dut.r_instr !== 16'h8005)
      begin errors++; $display("FAIL mid_refetch got req=%b instr=%h want 0 8005", if0.mem_req, dut.r_instr); end
  endtask

  initial begin
    prog0 = '{default: 16'h0013};
    prog1 = '{default: 16'h0013};
    for (int i = 0; i < 8; i++) prog1[i] = 16'h8001 + 16'(i);
    test_reset();
    test_add_out();
    test_wait_states();
    test_call_ret();
    test_alu_branch();
    test_overflow();
    test_underflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/stack_core.md
# stack_core

Parametrised stack-machine processor core. It fetches 16-bit instruction words from an external memory over a request/ready handshake, and executes them against on-chip data and return stacks whose width and depths are parameters. Compared with the fixed 16-bit core it adds asynchronous reset, memory wait states, stack overflow/underflow and illegal-opcode detection with a sticky fault code, a HALT instruction, and an output port in place of simulation printing. It sits between program memory and the board LED/output logic.

## Interface
- WIDTH, 16: data-stack and return-stack word width (≥16).
- DDEPTH, 16: data-stack entries (power of 2, ≥4).
- RDEPTH, 16: return-stack entries (power of 2, ≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- mem_addr  out  15  word address, equal to ip[15:1].
- mem_req  out  1  high while in FETCH.
- mem_rdata  in  16  instruction word; valid when mem_ready=1.
- mem_ready  in  1  the fetch completes on a cycle with mem_req & mem_ready.
- out_data  out  WIDTH  value popped by OUT.
- out_valid  out  1  one-cycle pulse per OUT.
- halted  out  1  core is stopped (HALT or fault).
- fault  out  3  0 none, 1 data-stack overflow, 2 data-stack underflow, 3 return-stack overflow, 4 return-stack underflow, 5 illegal opcode.

## Operation
- ip is a 16-bit byte address. The data stack pointer dsp counts 0..DDEPTH and the return stack pointer rsp counts 0..RDEPTH.
- States and transitions:
  - FETCH → EXEC_W if mem_rdata[15:13] ≠ 0.
  - FETCH → EXEC_H if the word is a byte pair and ip[0]=0.
  - FETCH → EXEC_L if ip[0]=1.
  - EXEC_H → EXEC_L.
  - EXEC_W and EXEC_L → FETCH.
  - Any fault or HALT → HALT. HALT is exited only by reset.
- Word instructions (ip must be even):
  - 1xxx: push the 15-bit literal, zero-extended; ip += 2.
  - 001: jump; ip = ip + 2 + sext(instr[12:0]).
  - 010: call; rpush(ip+2), then jump as above.
  - 011: conditional jump; pop, jump if the popped value is 0, else ip += 2.
- Byte opcodes: EXEC_H executes instr[15:8] and EXEC_L executes instr[7:0]. Each byte op does ip += 1 unless it is RET or HALT.
  - At ip odd, a low byte with bits [7:5] ≠ 0 is illegal.
  - 00 NOP; 01 OUT (pop → out_data).
  - 02 ADD, 03 SUB (NOS−TOS), both mod 2^WIDTH.
  - 04 DUP; 05 SWAP.
  - 06 ROT: new TOS=ROS, NOS=old TOS, ROS=old NOS.
  - 07 RET: ip = rpop.
  - 08 LT, 09 GT, 0A EQ: unsigned compare of NOS against TOS; result is all-ones or zero; net dsp −1.
  - 0B NOT (bitwise invert of TOS).
  - 0C RPUSH (pop data, push return); 0D RPOP (pop return, push data); 0E RCP (copy RTOS to data stack).
  - 0F AND; 10 OR; 11 XOR; 12 DROP.
  - 13 HALT; ip does not advance.
  - 14–1F are illegal.
- Fault check happens before any state update. A faulting instruction changes no stack, ip or output, and sets halted=1 and fault on the next edge.
  - Underflow: operands needed exceed dsp or rsp.
  - Overflow: the post-op count would exceed DDEPTH or RDEPTH.
  - Data-stack checks take precedence over return-stack checks.
- A fault or HALT in EXEC_H suppresses the low byte.

## Timing
- Reset values: ip=0, dsp=0, rsp=0, state FETCH, mem_req=1, mem_addr=0, out_valid=0, out_data=0, halted=0, fault=0. Stack RAM contents are undefined.
- Reset asserted mid-instruction aborts it immediately. A pending out_valid is cleared.
- FETCH holds mem_addr stable until mem_ready. Each idle cycle is one wait state.
- With mem_ready tied high:
  - a word instruction takes 2 cycles;
  - a byte pair takes 3 cycles;
  - an odd-ip single byte takes 2 cycles.
- out_valid rises on the edge that ends the OUT execute cycle, for exactly one cycle.
- halted and fault change only on exit from an execute state. They are sticky until rst.
- ip wraps mod 2^16.

## Test plan
- Program `0x8005, 0x8003, 0x0201` (push 5, push 3, ADD+OUT) with zero wait states → out_data=8 and out_valid pulses on cycle 7 after reset release; dsp=0.
- Same program with mem_ready low for 2 cycles of each fetch → identical result, out_valid on cycle 13; mem_addr held constant during the stalls.
- Call to a subroutine `0x8007, 0x0701` (push 7, RET+OUT), then `0x0113` at the return site → out_data=7, then halted=1, fault=0, rsp=0.
- DDEPTH=4, five literal pushes → the fifth faults: fault=1, halted=1, dsp=4, ip stays at 8.
- Opcode pair `0x0213` at ip=0 with an empty stack → ADD underflows: fault=2, and HALT in the low byte is not executed.
- Assert rst while stalled in FETCH at ip=6 → all outputs return to reset values that same cycle, and the next fetch is from mem_addr=0.
